// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory stage: access sizes,
// RISC-V load/store funct3 encodings and the request/response FSM states.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    localparam logic [2:0] F3_SD  = 3'd3;

    function automatic size_e size_of(input logic [2:0] funct3);
        return size_e'(funct3[1:0]);
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input size_e size);
        case (size)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_load_extend.sv
// Sign- or zero-extends the low 1/2/4/8 bytes of a raw little-endian
// memory word to the 64-bit value handed to writeback.
module load_extend
    import dmem_pkg::*;
(
    input  logic [63:0] raw,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [63:0] data
);

    logic fill_b;
    logic fill_h;
    logic fill_w;

    assign fill_b = ~is_unsigned & raw[7];
    assign fill_h = ~is_unsigned & raw[15];
    assign fill_w = ~is_unsigned & raw[31];

    always_comb begin
        data = raw;
        case (size)
            SZ_B:    data = {{56{fill_b}}, raw[7:0]};
            SZ_H:    data = {{48{fill_h}}, raw[15:0]};
            SZ_W:    data = {{32{fill_w}}, raw[31:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data memory with a two-state request/done handshake.
// Define DMEM_MISALIGN_TRAP_EN to suppress misaligned accesses (no write, zero load data).
module data_memory
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        ready,
    output logic        done,
    output logic [63:0] rdata,
    output logic        misaligned
);

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic [7:0]    mem [DEPTH];
    state_e        state;
    state_e        state_next;
    size_e         size;
    logic          is_unsigned;
    logic [AW-1:0] base;
    logic [AW-1:0] byte_addr [8];
    logic [7:0]    byte_en;
    logic [63:0]   raw;
    logic [63:0]   ext;
    logic          request;
    logic          accept;
    logic          mis_now;
    logic          allow;
    logic          unused_bits;

    assign unused_bits = ^{instruction[31:15], instruction[11:0], addr[63:AW]};

    assign size        = size_of(instruction[14:12]);
    assign is_unsigned = instruction[14];
    assign base        = addr[AW-1:0];
    assign request     = mem_read | mem_write;
    assign accept      = ready & request;
    assign mis_now     = |(addr[2:0] & align_mask(size));
    assign allow       = ~(TRAP_EN & mis_now);

    always_comb begin
        byte_en = 8'hFF;
        case (size)
            SZ_B:    byte_en = 8'h01;
            SZ_H:    byte_en = 8'h03;
            SZ_W:    byte_en = 8'h0F;
            default: byte_en = 8'hFF;
        endcase
    end

    // Each byte lane wraps independently at the top of memory.
    always_comb begin
        raw = '0;
        for (int i = 0; i < 8; i++) begin
            byte_addr[i]  = base + AW'(i);
            raw[8*i +: 8] = mem[byte_addr[i]];
        end
    end

    load_extend u_load_extend (
        .raw         (raw),
        .size        (size),
        .is_unsigned (is_unsigned),
        .data        (ext)
    );

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (request) begin
                    state_next = S_RESP;
                end
            end
            default: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rdata      <= '0;
            misaligned <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                misaligned <= mis_now;
                if (!mem_write) begin
                    rdata <= allow ? ext : '0;
                end
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && accept && mem_write && allow) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem[byte_addr[i]] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: behavioural byte-array model plus
// directed literal checks and randomized load/store traffic.
module tb_data_memory;

    localparam int DEPTH = 4096;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic        ready;
    logic        done;
    logic [63:0] rdata;
    logic        misaligned;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [63:0] last_rdata;
    logic        last_mis;
    logic        last_done;

    logic [7:0]  mm [DEPTH];
    logic        m_busy;
    logic [63:0] m_rdata;
    logic        m_mis;

    data_memory #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .addr        (addr),
        .wdata       (wdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ready       (ready),
        .done        (done),
        .rdata       (rdata),
        .misaligned  (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, got, exp);
        end
    endtask

    // Reference behaviour: one access per accepted request, applied to a plain byte array.
    always @(posedge clk) begin : model
        int          n;
        int          a;
        bit          mis;
        logic [63:0] val;
        if (rst) begin
            m_busy  = 1'b0;
            m_rdata = '0;
            m_mis   = 1'b0;
        end else if (!m_busy && (mem_read || mem_write)) begin
            n     = 1 << instruction[13:12];
            a     = int'(addr % 64'(DEPTH));
            mis   = (a % n) != 0;
            m_mis = mis;
            if (mem_write) begin
                if (!(TRAP && mis))
                    for (int i = 0; i < n; i++)
                        mm[(a + i) % DEPTH] = wdata[8*i +: 8];
            end else begin
                val = '0;
                if (!(TRAP && mis)) begin
                    for (int i = 0; i < n; i++)
                        val = val | (64'(mm[(a + i) % DEPTH]) << (8 * i));
                    if (!instruction[14] && n < 8 && val[8*n-1])
                        val = val | (~64'd0 << (8 * n));
                end
                m_rdata = val;
            end
            m_busy = 1'b1;
        end else begin
            m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("ready", 64'(ready), 64'(!m_busy));
            checkOutput("done", 64'(done), 64'(m_busy));
            checkOutput("rdata", rdata, m_rdata);
            checkOutput("misaligned", 64'(misaligned), 64'(m_mis));
        end
    end

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        instruction = {17'($urandom), f3, 12'($urandom)};
        addr        = a;
        wdata       = d;
        mem_read    = rd;
        mem_write   = wr;
        @(negedge clk);
        last_done  = done;
        last_rdata = rdata;
        last_mis   = misaligned;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int          pulses;
        int          kind;
        logic [63:0] a;
        rst = 1'b1; instruction = '0; addr = '0; wdata = '0;
        mem_read = 1'b0; mem_write = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        rst    = 1'b0;
        checkOutput("reset_ready", 64'(ready), 64'd1);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_rdata", rdata, 64'd0);
        checkOutput("reset_mis", 64'(misaligned), 64'd0);

        for (int k = 0; k < DEPTH / 8; k++)
            applyStimulus(1'b0, 1'b1, 3'd3, 64'(8 * k), {$urandom, $urandom});

        applyStimulus(1'b0, 1'b1, 3'd3, 64'h10, 64'h1122334455667788);
        checkOutput("sd_done", 64'(last_done), 64'd1);
        applyStimulus(1'b1, 1'b0, 3'd3, 64'h10, '0);
        checkOutput("ld_done", 64'(last_done), 64'd1);
        checkOutput("ld_10", last_rdata, 64'h1122334455667788);
        applyStimulus(1'b1, 1'b0, 3'd0, 64'h10, '0);
        checkOutput("lb_10", last_rdata, 64'hFFFF_FFFF_FFFF_FF88);
        applyStimulus(1'b1, 1'b0, 3'd4, 64'h10, '0);
        checkOutput("lbu_10", last_rdata, 64'h88);
        applyStimulus(1'b1, 1'b0, 3'd2, 64'h14, '0);
        checkOutput("lw_14", last_rdata, 64'h0000_0000_1122_3344);
        applyStimulus(1'b1, 1'b0, 3'd5, 64'h16, '0);
        checkOutput("lhu_16", last_rdata, 64'h1122);
        applyStimulus(1'b0, 1'b1, 3'd0, 64'h11, 64'h55AA_55AA_55AA_55AB);
        applyStimulus(1'b1, 1'b0, 3'd3, 64'h10, '0);
        checkOutput("ld_after_sb", last_rdata, 64'h1122_3344_5566_AB88);

        // Store coinciding with reset must be dropped.
        @(negedge clk);
        rst = 1'b1; mem_write = 1'b1; instruction = 32'h0000_3000;
        addr = 64'h10; wdata = 64'hDEAD_DEAD_DEAD_DEAD;
        @(negedge clk);
        rst = 1'b0; mem_write = 1'b0;
        applyStimulus(1'b1, 1'b0, 3'd3, 64'h10, '0);
        checkOutput("ld_after_rst_store", last_rdata, 64'h1122_3344_5566_AB88);

        // Reset arriving during the response cycle.
        applyStimulus(1'b1, 1'b0, 3'd3, 64'h10, '0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_resp_done", 64'(done), 64'd0);
        checkOutput("rst_in_resp_rdata", rdata, 64'd0);
        rst = 1'b0;

`ifdef DMEM_MISALIGN_TRAP_EN
        applyStimulus(1'b0, 1'b1, 3'd3, 64'h20, 64'h0123_4567_89AB_CDEF);
        applyStimulus(1'b0, 1'b1, 3'd1, 64'h21, 64'hFFFF);
        checkOutput("sh_21_mis", 64'(last_mis), 64'd1);
        applyStimulus(1'b1, 1'b0, 3'd3, 64'h20, '0);
        checkOutput("ld_20_unchanged", last_rdata, 64'h0123_4567_89AB_CDEF);
        applyStimulus(1'b1, 1'b0, 3'd1, 64'h21, '0);
        checkOutput("lh_21_zero", last_rdata, 64'd0);
        checkOutput("lh_21_mis", 64'(last_mis), 64'd1);
`else
        applyStimulus(1'b0, 1'b1, 3'd2, 64'(DEPTH - 2), 64'hDEAD_BEEF);
        checkOutput("sw_wrap_mis", 64'(last_mis), 64'd1);
        applyStimulus(1'b1, 1'b0, 3'd5, 64'h0, '0);
        checkOutput("lhu_0_wrap", last_rdata, 64'hDEAD);
        checkOutput("lhu_0_mis", 64'(last_mis), 64'd0);
        applyStimulus(1'b1, 1'b0, 3'd4, 64'(DEPTH - 1), '0);
        checkOutput("lbu_top", last_rdata, 64'hBE);
`endif

        // Request held high: accepted every other cycle.
        @(negedge clk);
        instruction = 32'h0000_3000; addr = 64'h10; mem_read = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        mem_read = 1'b0;
        checkOutput("held_pulses", 64'(pulses), 64'd3);

        for (int k = 0; k < 400; k++) begin
            kind = $urandom_range(0, 9);
            a    = {52'($urandom), 12'($urandom_range(0, DEPTH - 1))};
            if (kind == 9)
                @(negedge clk);
            else
                applyStimulus(kind <= 3 || kind == 8, kind >= 4, 3'($urandom_range(0, 7)),
                              a, {$urandom, $urandom});
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
